// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide scheduler for the E stage.
// Owns HI/LO. The arithmetic result is computed at accept into shadow
// registers; a busy counter models the fixed latency and HI/LO are
// committed on the final busy cycle's edge.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        flush,
  input  logic        d_use,
  input  logic        rd_sel,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] result
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_CNT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_CYCLES);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   sh_hi, sh_lo;
  logic          sh_vld;

  logic        is_md, is_valid, accept;
  logic [63:0] mul_a, mul_b, prod;
  logic        div_sgn, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag;
  logic [31:0] res_hi, res_lo;
  logic        res_ok;

  assign is_md    = (op <= 3'd3);
  assign is_valid = (op <= 3'd5);
  assign accept   = start & ~flush & ~busy & is_valid;

  // Multiply: sign- or zero-extend to 64 bits; the low 64 bits of the
  // product are correct for both signed and unsigned forms.
  assign mul_a = {(op[0] ? 32'h0 : {32{rs[31]}}), rs};
  assign mul_b = {(op[0] ? 32'h0 : {32{rt[31]}}), rt};
  assign prod  = mul_a * mul_b;

  // Divide on magnitudes, then restore signs: quotient truncates toward
  // zero, remainder follows the dividend. A zero divisor is replaced by 1
  // only to keep the divider defined; that result is never committed.
  assign div_sgn = (op == 3'd2);
  assign a_neg   = div_sgn & rs[31];
  assign b_neg   = div_sgn & rt[31];
  assign a_mag   = a_neg ? -rs : rs;
  assign b_mag   = b_neg ? -rt : rt;
  assign b_div   = (b_mag == 32'h0) ? 32'h1 : b_mag;
  assign q_mag   = a_mag / b_div;
  assign r_mag   = a_mag % b_div;

  // Select the HI/LO pair for the operation being accepted.
  always_comb begin
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    res_ok = 1'b1;
    if (op[1]) begin
      res_lo = (a_neg ^ b_neg) ? -q_mag : q_mag;
      res_hi = a_neg ? -r_mag : r_mag;
      res_ok = (rt != 32'h0);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: enter RUN on an accepted mul/div, leave on last count.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && is_md) state_nxt = RUN;
      RUN:  if (cnt == CW'(1))   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: busy while running, stall D-stage MDU users, HI/LO read mux.
  always_comb begin
    busy   = (state == RUN);
    stall  = d_use & (busy | (start & ~flush & is_md));
    result = rd_sel ? lo : hi;
  end

  // Datapath: shadow capture and counter load at accept, MT* writes,
  // countdown and commit while running.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      sh_hi  <= '0;
      sh_lo  <= '0;
      sh_vld <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        if (is_md) begin
          cnt    <= op[1] ? DIV_CNT : MULT_CNT;
          sh_hi  <= res_hi;
          sh_lo  <= res_lo;
          sh_vld <= res_ok;
        end else if (op == 3'd4) begin
          hi <= rs;
        end else begin
          lo <= rs;
        end
      end
    end else begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1) && sh_vld) begin
        hi <= sh_hi;
        lo <= sh_lo;
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed and randomized checks of mdu_ctrl against a
// plain-arithmetic HI/LO model.
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start, flush, d_use, rd_sel;
  logic [2:0]  op;
  logic [31:0] rs, rt;
  logic        busy, stall;
  logic [31:0] hi, lo, result;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi, m_lo;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .flush(flush), .d_use(d_use), .rd_sel(rd_sel), .busy(busy),
    .stall(stall), .hi(hi), .lo(lo), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: next HI/LO from the architectural rules.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    eh = m_hi;
    el = m_lo;
    case (o)
      3'd0: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
      3'd1: begin p = {32'h0, a} * {32'h0, b}; eh = p[63:32]; el = p[31:0]; end
      3'd2: if (b != 0) begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; end
      3'd3: if (b != 0) begin el = a / b; eh = a % b; end
      3'd4: eh = a;
      3'd5: el = a;
      default: ;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] o);
    return (o <= 3'd1) ? MC : (o <= 3'd3) ? DC : 0;
  endfunction

  // Issue one op and follow it to completion. poke: 0 none,
  // 1 start during RUN, 2 flush pulse during RUN.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic du, input int poke);
    logic [31:0] eh, el;
    int n;
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b; d_use = du; flush = 1'b0;
    #1;
    chk("stall_start", {31'h0, stall}, {31'h0, du & (o <= 3'd3)});
    chk("busy_start", {31'h0, busy}, 32'h0);
    model(o, a, b, eh, el);
    n = latency(o);
    @(negedge clk);
    start = 1'b0; rs = $urandom; rt = $urandom;
    for (int i = 1; i <= n; i++) begin
      if (i == 2 && poke == 1) begin
        start = 1'b1; op = 3'($urandom_range(0, 5));
        $display("note: start while busy at cycle %0d (protocol violation, must be ignored)", i);
      end
      if (i == 2 && poke == 2) flush = 1'b1;
      rd_sel = 1'($urandom);
      #1;
      chk("busy_run", {31'h0, busy}, 32'h1);
      chk("stall_run", {31'h0, stall}, {31'h0, du});
      chk("hi_run", hi, m_hi);
      chk("lo_run", lo, m_lo);
      chk("result_run", result, rd_sel ? m_lo : m_hi);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
    end
    m_hi = eh; m_lo = el;
    rd_sel = 1'b0;
    #1;
    chk("busy_done", {31'h0, busy}, 32'h0);
    chk("stall_done", {31'h0, stall}, 32'h0);
    chk("hi_done", hi, m_hi);
    chk("lo_done", lo, m_lo);
    chk("result_hi", result, m_hi);
    rd_sel = 1'b1;
    #1;
    chk("result_lo", result, m_lo);
  endtask

  // Start with flush: nothing may change.
  task automatic flushed_start(input logic [2:0] o, input logic [31:0] a);
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = o; rs = a; rt = 32'h3; d_use = 1'b1;
    #1;
    chk("stall_flush", {31'h0, stall}, 32'h0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0; d_use = 1'b0;
    #1;
    chk("busy_flush", {31'h0, busy}, 32'h0);
    chk("hi_flush", hi, m_hi);
    chk("lo_flush", lo, m_lo);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; d_use = 1'b0; rd_sel = 1'b0;
    op = 3'd0; rs = 32'h0; rt = 32'h0;
    m_hi = 32'h0; m_lo = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_result", result, 32'h0);

    // Multiplies
    do_op(3'd0, 32'hFFFFFFFD, 32'd5, 1'b1, 0);
    chk("mult_hi_k", hi, 32'hFFFFFFFF);
    chk("mult_lo_k", lo, 32'hFFFFFFF1);
    do_op(3'd1, 32'hFFFFFFFD, 32'd5, 1'b0, 0);
    chk("multu_hi_k", hi, 32'h00000004);
    chk("multu_lo_k", lo, 32'hFFFFFFF1);

    // Divides
    do_op(3'd3, 32'd100, 32'd7, 1'b0, 0);
    chk("divu_lo_k", lo, 32'd14);
    chk("divu_hi_k", hi, 32'd2);
    do_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 0);
    chk("div_lo_k", lo, 32'hFFFFFFFD);
    chk("div_hi_k", hi, 32'hFFFFFFFF);
    do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0);
    chk("divovf_lo_k", lo, 32'h80000000);
    chk("divovf_hi_k", hi, 32'h0);

    // Divide by zero keeps preloaded HI/LO
    do_op(3'd4, 32'h11, 32'h0, 1'b0, 0);
    do_op(3'd5, 32'h22, 32'h0, 1'b0, 0);
    do_op(3'd2, 32'h1234, 32'h0, 1'b0, 0);
    chk("div0_hi_k", hi, 32'h11);
    chk("div0_lo_k", lo, 32'h22);
    do_op(3'd4, 32'hABCD, 32'h0, 1'b1, 0);
    chk("mthi_k", hi, 32'hABCD);

    // Start during RUN ignored; flush during RUN does not cancel
    do_op(3'd0, 32'd7, 32'd9, 1'b1, 1);
    chk("ign_lo_k", lo, 32'd63);
    do_op(3'd3, 32'd50, 32'd6, 1'b0, 2);
    chk("flushrun_lo_k", lo, 32'd8);

    // Flushed starts
    flushed_start(3'd0, 32'h55);
    flushed_start(3'd5, 32'h66);

    // Reset at busy cycle 3 of a DIV
    @(negedge clk);
    start = 1'b1; op = 3'd3; rs = 32'd99; rt = 32'd4; d_use = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_busy", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'h0; m_lo = 32'h0;
    #1;
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    do_op(3'd0, 32'd1000, 32'd1000, 1'b1, 0);
    chk("postrst_lo_k", lo, 32'd1000000);

    // Randomized mix
    for (int k = 0; k < 40; k++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      if ($urandom_range(0, 5) == 0)
        flushed_start(3'($urandom_range(0, 5)), $urandom);
      do_op(ro, ra, rb, 1'($urandom), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multi-cycle multiply/divide scheduler for the E stage of the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E and owns the HI/LO registers. It sequences the fixed-latency operation with a busy counter and raises the pipeline stall request for MDU-dependent instructions in D. It returns HI or LO to the E-stage result select for MFHI/MFLO, and honours the exception flush from CP0.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  E-stage MDU instruction valid this cycle
op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO, 6-7 no-op
rs  input  32  operand A / MTHI-MTLO source
rt  input  32  operand B
flush  input  1  CP0 exception/interrupt, cancels the E-stage instruction this cycle
d_use  input  1  D-stage instruction is MULT/DIV/MT*/MF*
rd_sel  input  1  0=HI, 1=LO, for MFHI/MFLO read
busy  output  1  operation in progress
stall  output  1  stall request to hazard unit
hi  output  32  HI register
lo  output  32  LO register
result  output  32  rd_sel ? lo : hi (combinational)

Behaviour:
- Reset (sync, highest priority): state IDLE, counter 0, busy 0, hi 0, lo 0, shadow regs 0. Reset mid-operation abandons the op; no HI/LO commit.
- FSM states: IDLE, RUN.
- Accept condition: accept = start & ~flush & ~busy & op in 0..5. A start with flush high has no effect on any state.
- IDLE, accept, op 0-3:
  - Compute the result into shadow regs sh_hi/sh_lo at this edge.
  - Load counter with MULT_CYCLES or DIV_CYCLES. Go to RUN.
- IDLE, accept, op 4/5: hi<=rs (MTHI) or lo<=rs (MTLO) at this edge. Stay IDLE; busy stays 0.
- RUN:
  - busy=1. Counter decrements each cycle.
  - On the edge where the counter equals 1: hi<=sh_hi, lo<=sh_lo, go to IDLE.
  - Net timing: busy is high for exactly N consecutive cycles, starting the cycle after accept. New HI/LO is visible in the first cycle with busy=0.
- Start while busy: ignored, no state change. The hazard unit guarantees this does not occur; the bench flags it as a protocol violation but the RTL must tolerate it.
- Flush while RUN does not cancel. The instruction already left E; the op completes and commits.
- Arithmetic:
  - MULT: signed 32x32 -> 64 product, {hi,lo}.
  - MULTU: unsigned 32x32 -> 64 product, {hi,lo}.
  - DIV: signed; lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned; lo = quotient, hi = remainder.
  - Divide by zero (rt==0, DIV/DIVU): runs the full DIV_CYCLES with busy, but the commit leaves hi/lo unchanged.
  - 0x80000000 / 0xFFFFFFFF (DIV): lo=0x80000000, hi=0.
- stall = d_use & (busy | (start & ~flush & op in 0..3)). This is combinational. MT* in E does not stall, because its write lands before D reaches E.
- result is combinational from the current hi/lo. A read in the commit cycle returns the old value; a read in the next cycle returns the new value.
- op 6/7 with start: no-op, no busy, no stall contribution.

Test Plan:
- MULT rs=0xFFFFFFFD(-3), rt=5 -> busy high cycles 1..5 after start; at cycle 6 hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU same operands -> hi=0x00000004, lo=0xFFFFFFF1.
- DIVU 100/7 -> busy 10 cycles, then lo=14, hi=2. DIV 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV by zero with hi=0x11, lo=0x22 preloaded via MTHI/MTLO -> busy 10 cycles, then hi=0x11, lo=0x22. MTHI 0xABCD -> hi=0xABCD next cycle, busy never high.
- Stall/read: MULT start with d_use=1 -> stall=1 in the start cycle and all 5 busy cycles, 0 after. rd_sel toggles return hi/lo. Start asserted during RUN -> ignored; the original result commits on schedule.
- Flush: start=1 with flush=1 (MULT, then MTLO) -> busy stays 0, hi/lo unchanged, stall=0. Flush pulsed mid-RUN -> result still commits at cycle N.
- Reset asserted at busy cycle 3 of a DIV -> next cycle busy=0, hi=0, lo=0, state IDLE. A new MULT is accepted immediately afterwards and completes normally.
